mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes the EX/MEM register outputs and performs load/store through a valid/ready data-memory port.
- Stalls the pipeline while an access is outstanding, then produces the MEM/WB stage register.
- Also supplies the MEM-stage forwarding value and destination info to the forwarding unit.

---
 rtl/mem_stage.sv | 86 ++++++++
 tb/tb_mem_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with valid/ready dmem port, stall generation and MEM/WB register
module mem_stage #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stage_EX_MEM__MEM_regwrite,
  input  logic        stage_EX_MEM__MEM_memtoreg,
  input  logic        stage_EX_MEM__MEM_memread,
  input  logic        stage_EX_MEM__MEM_memwrite,
  input  logic [31:0] stage_EX_MEM__MEM_alures,
  input  logic [31:0] stage_EX_MEM__MEM_store_data,
  input  logic [4:0]  stage_EX_MEM__MEM_rd_id,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [29:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        MEM_stall_for_dmem,
  output logic        dmem_err,
  output logic [31:0] MEM__EX_for_help,
  output logic        MEM__FU_regwrite,
  output logic [4:0]  MEM__FU_rd_id,
  output logic        stage_MEM_WB__WB_regwrite,
  output logic        stage_MEM_WB__WB_memtoreg,
  output logic [31:0] stage_MEM_WB__WB_alures,
  output logic [31:0] stage_MEM_WB__WB_mem_data,
  output logic [4:0]  stage_MEM_WB__WB_rd_id
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0] hold_data, mem_val;
  logic acc, busy, to, done;
  assign acc = stage_EX_MEM__MEM_memread | stage_EX_MEM__MEM_memwrite;
  assign busy = state == REQ || state == RESP;
  assign to = TIMEOUT != 0 && busy && cnt == CNT_W'(TIMEOUT);
  // memwrite dominates, so a simultaneous read+write completes as a store
  assign done = to
    || (state == IDLE || state == REQ) && acc && stage_EX_MEM__MEM_memwrite && dmem_req_ready
    || state == RESP && dmem_rsp_valid;
  assign dmem_req_valid = !rst && (state == IDLE && acc || state == REQ && !to);
  assign dmem_req_we = stage_EX_MEM__MEM_memwrite;
  assign dmem_req_addr = stage_EX_MEM__MEM_alures[31:2];
  assign dmem_req_wdata = stage_EX_MEM__MEM_store_data;
  assign MEM_stall_for_dmem = (state == IDLE && acc || busy) && !done;
  assign MEM__EX_for_help = stage_EX_MEM__MEM_alures;
  assign MEM__FU_regwrite = stage_EX_MEM__MEM_regwrite;
  assign MEM__FU_rd_id = stage_EX_MEM__MEM_rd_id;
  assign mem_val = state == HOLD ? hold_data
    : state == RESP && dmem_rsp_valid && !to ? dmem_rsp_rdata : '0;
  always_comb
    state_nx = done ? (en ? IDLE : HOLD)
      : state == IDLE ? (acc ? (dmem_req_ready ? RESP : REQ) : IDLE)
      : state == REQ ? (dmem_req_ready ? RESP : REQ)
      : state == HOLD ? (en ? IDLE : HOLD) : RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dmem_err <= 1'b0;
      hold_data <= '0;
      stage_MEM_WB__WB_regwrite <= 1'b0;
      stage_MEM_WB__WB_memtoreg <= 1'b0;
      stage_MEM_WB__WB_alures <= '0;
      stage_MEM_WB__WB_mem_data <= '0;
      stage_MEM_WB__WB_rd_id <= '0;
    end else begin
      state <= state_nx;
      cnt <= done ? '0 : busy ? cnt + 1'b1 : cnt;
      dmem_err <= dmem_err | to;
      if (done) hold_data <= mem_val;
      if (en) begin
        stage_MEM_WB__WB_regwrite <= MEM_stall_for_dmem ? 1'b0 : stage_EX_MEM__MEM_regwrite;
        stage_MEM_WB__WB_memtoreg <= MEM_stall_for_dmem ? 1'b0 : stage_EX_MEM__MEM_memtoreg;
        stage_MEM_WB__WB_alures <= MEM_stall_for_dmem ? '0 : stage_EX_MEM__MEM_alures;
        stage_MEM_WB__WB_mem_data <= MEM_stall_for_dmem ? '0 : mem_val;
        stage_MEM_WB__WB_rd_id <= MEM_stall_for_dmem ? '0 : stage_EX_MEM__MEM_rd_id;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (TIMEOUT = 4)
module tb_mem_stage;
  logic clk = 0, rst = 1, en = 0;
  logic regwrite = 0, memtoreg = 0, memread = 0, memwrite = 0;
  logic [31:0] alures = 0, sdata = 0, rdata = 0;
  logic [4:0] rd = 0;
  logic ready = 0, rsp_valid = 0;
  logic req_valid, req_we, stall, err, fu_regwrite, wb_regwrite, wb_memtoreg;
  logic [29:0] req_addr;
  logic [31:0] req_wdata, for_help, wb_alures, wb_mem_data;
  logic [4:0] fu_rd_id, wb_rd_id;
  int pass = 0, total = 0, n = 0, nreq = 0;
  always #5 clk = ~clk;
  mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .stage_EX_MEM__MEM_regwrite(regwrite), .stage_EX_MEM__MEM_memtoreg(memtoreg),
    .stage_EX_MEM__MEM_memread(memread), .stage_EX_MEM__MEM_memwrite(memwrite),
    .stage_EX_MEM__MEM_alures(alures), .stage_EX_MEM__MEM_store_data(sdata),
    .stage_EX_MEM__MEM_rd_id(rd),
    .dmem_req_valid(req_valid), .dmem_req_ready(ready), .dmem_req_we(req_we),
    .dmem_req_addr(req_addr), .dmem_req_wdata(req_wdata),
    .dmem_rsp_valid(rsp_valid), .dmem_rsp_rdata(rdata),
    .MEM_stall_for_dmem(stall), .dmem_err(err), .MEM__EX_for_help(for_help),
    .MEM__FU_regwrite(fu_regwrite), .MEM__FU_rd_id(fu_rd_id),
    .stage_MEM_WB__WB_regwrite(wb_regwrite), .stage_MEM_WB__WB_memtoreg(wb_memtoreg),
    .stage_MEM_WB__WB_alures(wb_alures), .stage_MEM_WB__WB_mem_data(wb_mem_data),
    .stage_MEM_WB__WB_rd_id(wb_rd_id)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    regwrite = 0; memtoreg = 0; memread = 0; memwrite = 0; ready = 0; rsp_valid = 0;
  endtask
  task automatic wb_chk(input string tag, input logic rw, input logic mt, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
    chk({tag, "_regwrite"}, 32'(wb_regwrite), 32'(rw));
    chk({tag, "_memtoreg"}, 32'(wb_memtoreg), 32'(mt));
    chk({tag, "_alures"}, wb_alures, a);
    chk({tag, "_mem_data"}, wb_mem_data, d);
    chk({tag, "_rd_id"}, 32'(wb_rd_id), 32'(r));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    // reset, with an access pending to prove req_valid is masked
    memread = 1;
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 0);
    tick();
    @(negedge clk);
    wb_chk("rst", 0, 0, 0, 0, 0);
    chk("rst_err", 32'(err), 0);
    tick();
    rst = 0; memread = 0; en = 1;
    // single-cycle store
    memwrite = 1; alures = 32'h100; sdata = 32'hDEADBEEF; rd = 3; ready = 1;
    @(negedge clk);
    chk("st_req_valid", 32'(req_valid), 1);
    chk("st_we", 32'(req_we), 1);
    chk("st_addr", 32'(req_addr), 32'h40);
    chk("st_wdata", req_wdata, 32'hDEADBEEF);
    chk("st_stall", 32'(stall), 0);
    chk("st_fwd", for_help, 32'h100);
    chk("st_fu_rd", 32'(fu_rd_id), 3);
    tick();
    idle();
    @(negedge clk);
    wb_chk("st_wb", 0, 0, 32'h100, 0, 3);
    chk("idle_req_valid", 32'(req_valid), 0);
    tick();
    // load with response on the third RESP cycle
    regwrite = 1; memtoreg = 1; memread = 1; alures = 32'h204; rd = 5; ready = 1;
    @(negedge clk);
    chk("ld0_req_valid", 32'(req_valid), 1);
    chk("ld0_we", 32'(req_we), 0);
    chk("ld0_addr", 32'(req_addr), 32'h81);
    chk("ld0_stall", 32'(stall), 1);
    chk("ld0_fu_regwrite", 32'(fu_regwrite), 1);
    tick();
    ready = 0;
    @(negedge clk);
    chk("ld1_req_valid", 32'(req_valid), 0);
    chk("ld1_stall", 32'(stall), 1);
    chk("ld1_bubble_alures", wb_alures, 0);
    chk("ld1_bubble_regwrite", 32'(wb_regwrite), 0);
    tick();
    @(negedge clk);
    chk("ld2_stall", 32'(stall), 1);
    tick();
    rsp_valid = 1; rdata = 32'h12345678;
    @(negedge clk);
    chk("ld3_stall", 32'(stall), 0);
    tick();
    idle(); rdata = 0;
    @(negedge clk);
    wb_chk("ld_wb", 1, 1, 32'h204, 32'h12345678, 5);
    tick();
    // store under back-pressure
    regwrite = 1; memwrite = 1; alures = 32'h3C8; sdata = 32'hCAFEF00D; rd = 6; ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ready = 1;
      @(negedge clk);
      chk("bp_req_valid", 32'(req_valid), 1);
      chk("bp_addr", 32'(req_addr), 32'hF2);
      chk("bp_wdata", req_wdata, 32'hCAFEF00D);
      chk("bp_stall", 32'(stall), i < 4 ? 1 : 0);
      if (i > 0) begin
        chk("bp_bubble_regwrite", 32'(wb_regwrite), 0);
        chk("bp_bubble_alures", wb_alures, 0);
      end
      tick();
    end
    idle();
    @(negedge clk);
    wb_chk("bp_wb", 1, 0, 32'h3C8, 0, 6);
    chk("bp_err", 32'(err), 0);
    tick();
    // load completing while the pipeline is held
    en = 0; regwrite = 1; memtoreg = 1; memread = 1; alures = 32'h010; rd = 7; ready = 1;
    @(negedge clk);
    nreq += int'(req_valid);
    chk("h0_stall", 32'(stall), 1);
    tick();
    ready = 0; rsp_valid = 1; rdata = 32'hA5A55A5A;
    @(negedge clk);
    nreq += int'(req_valid);
    chk("h1_stall", 32'(stall), 0);
    tick();
    rsp_valid = 0; rdata = 32'hFFFFFFFF;
    @(negedge clk);
    nreq += int'(req_valid);
    chk("h2_stall", 32'(stall), 0);
    chk("h2_wb_frozen", wb_alures, 32'h3C8);
    tick();
    en = 1;
    @(negedge clk);
    nreq += int'(req_valid);
    chk("h3_stall", 32'(stall), 0);
    chk("h_one_request", 32'(nreq), 1);
    tick();
    idle();
    @(negedge clk);
    wb_chk("h_wb", 1, 1, 32'h010, 32'hA5A55A5A, 7);
    chk("h_after_req_valid", 32'(req_valid), 0);
    tick();
    // load that never gets a response
    regwrite = 1; memtoreg = 1; memread = 1; alures = 32'h400; rd = 9; ready = 1;
    @(negedge clk);
    chk("to0_stall", 32'(stall), 1);
    n = 1;
    tick();
    ready = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      tick();
    end
    chk("to_stall_cycles", 32'(n), 5);
    chk("to_err_before", 32'(err), 0);
    tick();
    idle();
    @(negedge clk);
    chk("to_err", 32'(err), 1);
    wb_chk("to_wb", 1, 1, 32'h400, 0, 9);
    tick();
    tick();
    @(negedge clk);
    chk("to_err_sticky", 32'(err), 1);
    tick();
    // reset in the middle of a load, then a stray response
    regwrite = 1; memread = 1; alures = 32'h80; rd = 4; ready = 1;
    tick();
    ready = 0; rst = 1;
    @(negedge clk);
    chk("rr_req_valid", 32'(req_valid), 0);
    tick();
    rst = 0; idle(); rsp_valid = 1; rdata = 32'h11111111;
    @(negedge clk);
    wb_chk("rr_wb", 0, 0, 0, 0, 0);
    chk("rr_err", 32'(err), 0);
    chk("rr_stall", 32'(stall), 0);
    chk("rr_req_valid2", 32'(req_valid), 0);
    tick();
    rsp_valid = 0;
    @(negedge clk);
    chk("rr_late_rsp_ignored", wb_mem_data, 0);
    chk("rr_late_regwrite", 32'(wb_regwrite), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
